execute_lsu: RTL and testbench
==============================

Name: execute_lsu

Overview:
- Load/store unit that sits directly beside the execute-stage controller.
- It starts when the controller holds access_begin and runs exactly one AXI4-Lite read or write to data memory.
- Loads: aligns and sign- or zero-extends the returned data. Stores: generates byte strobes.
- Reports completion with a one-cycle access_done pulse, which moves the controller from mem_access to wait_ready.

Parameters:
ADDR_WIDTH  32  byte-address width on the request and AXI address channels
DATA_WIDTH  32  data width; only 32 is supported

Ports:
clock          input   1   system clock
reset          input   1   asynchronous, active-low reset
access_begin_i input   1   level; high while execute controller is in mem_access
lsu_op_i       input   4   0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW; other codes illegal
addr_i         input   32  effective byte address
wdata_i        input   32  store data, value in LSBs
access_done_o  output  1   one-cycle completion pulse
rdata_o        output  32  extended load result; held until next access
fault_o        output  1   misaligned/illegal op or non-OKAY response; valid with done, held
araddr_o       output  32  AXI read address
arvalid_o      output  1
arready_i      input   1
rdata_i        input   32
rresp_i        input   2
rvalid_i       input   1
rready_o       output  1
awaddr_o       output  32
awvalid_o      output  1
awready_i      input   1
wdata_o        output  32
wstrb_o        output  4
wvalid_o       output  1
wready_i       input   1
bresp_i        input   2
bvalid_i       input   1
bready_o       output  1

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; every output 0, including rdata_o and fault_o.
- IDLE: on access_begin_i=1, latch lsu_op_i, addr_i and wdata_i. Later input changes are ignored until the next IDLE.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal op → DONE, fault_o=1, no bus activity.
  - Otherwise load → RD_ADDR; store → WR_REQ.
- Bus addresses: araddr/awaddr = {addr[31:2],2'b00}.
- RD_ADDR: arvalid=1 and held, with araddr stable, until arready. On the handshake → RD_DATA.
- RD_DATA: rready=1. On rvalid, shift rdata_i right by addr[1:0]*8, then extend per op:
  - LB/LH: sign-extend bit 7 / bit 15.
  - LBU/LHU: zero-extend.
  - LW: unchanged.
  - Register the result into rdata_o; fault_o = (rresp!=0) → DONE.
- WR_REQ: awvalid and wvalid both 1.
  - Each channel drops independently after its own handshake; track accepted flags. The same-cycle handshake of both is legal.
  - When both are accepted → WR_RESP.
  - wdata_o = wdata_i shifted left by addr[1:0]*8.
  - wstrb: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
- WR_RESP: bready=1. On bvalid, fault_o = (bresp!=0) → DONE. rdata_o is left unchanged.
- DONE: access_done_o=1 for exactly this cycle → IDLE.
  - The controller leaves mem_access on this same edge, so access_begin is low in the following IDLE cycle. No re-trigger occurs.
  - If access_begin_i is still high in IDLE, it is a new access.
- Latency with zero-wait slave:
  - Load: begin seen at cycle 0; ar handshake cycle 1; r handshake cycle 2; done cycle 3.
  - Store: begin cycle 0; aw+w cycle 1; b cycle 2; done cycle 3.
  - Misaligned/illegal: done cycle 1.
- rdata_o/fault_o stay stable from DONE until the next access leaves IDLE. fault_o clears on the next start.
- Reset mid-transaction: state and all outputs to 0 immediately. The outstanding AXI transaction is abandoned; the system reset also resets memory.
- Never more than one outstanding transaction. Read and write channels are never active together.

Test Plan:
- LB, addr 0x80000003, memory word 0x80AB_CDEF → araddr 0x80000000; rdata_o 0xFFFF_FF80; done at cycle 3; fault_o 0.
- LHU, addr 0x80000002, word 0x8001_1234 → rdata_o 0x0000_8001. Same with LH → 0xFFFF_8001.
- SH, addr 0x80000102, wdata 0x0000_BEEF → awaddr 0x80000100, wdata_o 0xBEEF_0000, wstrb 4'b1100; done after bvalid.
- SW with awready delayed 3 cycles while wready is immediate → wvalid drops after 1 cycle; awvalid held stable; single done pulse after b.
- LW, addr 0x80000001 → no arvalid; fault_o=1 with done at cycle 1. Also LW with rresp=2'b10 → fault_o=1.
- Assert reset=0 during RD_DATA → all outputs 0 asynchronously. After release, a new LW completes normally with fault_o 0.

Source files
------------

// File: rtl/execute_lsu.sv
// execute_lsu: single-access AXI4-Lite load/store unit beside the execute controller.
// Loads are aligned and extended into rdata_o; stores are shifted onto byte lanes with strobes.
module execute_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  access_begin_i,
   input  logic [3:0]            lsu_op_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  access_done_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  fault_o,
   output logic [ADDR_WIDTH-1:0] araddr_o,
   output logic                  arvalid_o,
   input  logic                  arready_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic [1:0]            rresp_i,
   input  logic                  rvalid_i,
   output logic                  rready_o,
   output logic [ADDR_WIDTH-1:0] awaddr_o,
   output logic                  awvalid_o,
   input  logic                  awready_i,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic [3:0]            wstrb_o,
   output logic                  wvalid_o,
   input  logic                  wready_i,
   input  logic [1:0]            bresp_i,
   input  logic                  bvalid_i,
   output logic                  bready_o
);
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
   state_t r_state, w_next;
   logic [3:0]            r_op;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
   logic [3:0]            r_wstrb;
   logic                  r_fault, r_aw_acc, r_w_acc;
   logic                  w_illegal, w_misaligned, w_bad, w_aw_acc, w_w_acc;
   logic [DATA_WIDTH-1:0] w_shifted, w_load;
   // Legal codes are 0,1,2,4,5,8,9,10: size field 3, or bit 2 combined with bit 1 or bit 3, is illegal.
   assign w_illegal    = (lsu_op_i[1:0] == 2'd3) | (lsu_op_i[2] & lsu_op_i[1]) | (lsu_op_i[3] & lsu_op_i[2]);
   assign w_misaligned = (lsu_op_i[1:0] == 2'd1) ? addr_i[0] : (lsu_op_i[1:0] == 2'd2) ? |addr_i[1:0] : 1'b0;
   assign w_bad        = w_illegal | w_misaligned;
   assign w_aw_acc     = r_aw_acc | awready_i;
   assign w_w_acc      = r_w_acc | wready_i;
   assign w_shifted    = rdata_i >> {r_addr[1:0], 3'b000};
   assign w_load       = (r_op[1:0] == 2'd0) ? {{24{~r_op[2] & w_shifted[7]}}, w_shifted[7:0]} :
                         (r_op[1:0] == 2'd1) ? {{16{~r_op[2] & w_shifted[15]}}, w_shifted[15:0]} : w_shifted;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (access_begin_i) w_next = w_bad ? DONE : (lsu_op_i[3] ? WR_REQ : RD_ADDR);
         RD_ADDR: if (arready_i) w_next = RD_DATA;
         RD_DATA: if (rvalid_i) w_next = DONE;
         WR_REQ:  if (w_aw_acc && w_w_acc) w_next = WR_RESP;
         WR_RESP: if (bvalid_i) w_next = DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_op     <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_rdata  <= '0;
         r_fault  <= 1'b0;
         r_aw_acc <= 1'b0;
         r_w_acc  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && access_begin_i) begin
            r_op     <= lsu_op_i;
            r_addr   <= addr_i;
            r_wdata  <= wdata_i << {addr_i[1:0], 3'b000};
            r_wstrb  <= (lsu_op_i[1:0] == 2'd0) ? 4'b0001 << addr_i[1:0] :
                        (lsu_op_i[1:0] == 2'd1) ? 4'b0011 << addr_i[1:0] : 4'b1111;
            r_fault  <= w_bad;
            r_aw_acc <= 1'b0;
            r_w_acc  <= 1'b0;
         end
         if (r_state == RD_DATA && rvalid_i) begin
            r_rdata <= w_load;
            r_fault <= |rresp_i;
         end
         if (r_state == WR_REQ) begin
            r_aw_acc <= w_aw_acc;
            r_w_acc  <= w_w_acc;
         end
         if (r_state == WR_RESP && bvalid_i) r_fault <= |bresp_i;
      end
   end
   assign access_done_o = r_state == DONE;
   assign rdata_o       = r_rdata;
   assign fault_o       = r_fault;
   assign araddr_o      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
   assign awaddr_o      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
   assign arvalid_o     = r_state == RD_ADDR;
   assign rready_o      = r_state == RD_DATA;
   assign awvalid_o     = r_state == WR_REQ && !r_aw_acc;
   assign wvalid_o      = r_state == WR_REQ && !r_w_acc;
   assign bready_o      = r_state == WR_RESP;
   assign wdata_o       = r_wdata;
   assign wstrb_o       = r_wstrb;
endmodule

// File: tb/tb_execute_lsu.sv
// tb_execute_lsu: directed checks of execute_lsu against hand-computed AXI and result values.
module tb_execute_lsu;
   logic        clock = 1'b0, reset, access_begin_i;
   logic [3:0]  lsu_op_i;
   logic [31:0] addr_i, wdata_i, rdata_i;
   logic        access_done_o, fault_o, arvalid_o, arready_i, rvalid_i, rready_o;
   logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
   logic [31:0] rdata_o, araddr_o, awaddr_o, wdata_o;
   logic [3:0]  wstrb_o;
   logic [1:0]  rresp_i, bresp_i;
   int          checks = 0, errors = 0, cyc;

   execute_lsu dut (
      .clock(clock), .reset(reset), .access_begin_i(access_begin_i), .lsu_op_i(lsu_op_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .access_done_o(access_done_o), .rdata_o(rdata_o),
      .fault_o(fault_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i), .wdata_o(wdata_o),
      .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i), .bresp_i(bresp_i),
      .bvalid_i(bvalid_i), .bready_o(bready_o)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
      access_begin_i = 1'b1; lsu_op_i = op; addr_i = a; wdata_i = d;
      tick;
      access_begin_i = 1'b0; lsu_op_i = 4'hF; addr_i = '1; wdata_i = '1;
   endtask

   task automatic wait_done(input string tag, output int c);
      c = 1;
      while (!access_done_o && c < 50) begin
         tick;
         c++;
      end
      chk({tag, "_done_seen"}, {31'd0, access_done_o}, 32'd1);
   endtask

   initial begin
      access_begin_i = 0; lsu_op_i = 0; addr_i = 0; wdata_i = 0;
      arready_i = 1; rvalid_i = 1; rdata_i = 0; rresp_i = 0;
      awready_i = 1; wready_i = 1; bvalid_i = 1; bresp_i = 0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("rst_outs", {access_done_o, fault_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, wstrb_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      tick; tick;
      #2 reset = 1'b1;
      tick;

      // LB from byte 3, sign bit set
      rdata_i = 32'h80AB_CDEF;
      launch(4'd0, 32'h8000_0003, 32'd0);
      chk("lb_arvalid", {31'd0, arvalid_o}, 32'd1);
      chk("lb_araddr", araddr_o, 32'h8000_0000);
      tick;
      chk("lb_rready", {31'd0, rready_o}, 32'd1);
      chk("lb_arvalid_drop", {31'd0, arvalid_o}, 32'd0);
      tick;
      chk("lb_done_c3", {31'd0, access_done_o}, 32'd1);
      chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
      chk("lb_fault", {31'd0, fault_o}, 32'd0);
      tick;
      chk("lb_done_pulse", {31'd0, access_done_o}, 32'd0);
      chk("lb_rdata_held", rdata_o, 32'hFFFF_FF80);

      rdata_i = 32'h8001_1234;
      launch(4'd5, 32'h8000_0002, 32'd0);
      wait_done("lhu", cyc);
      chk("lhu_cyc", cyc, 3);
      chk("lhu_rdata", rdata_o, 32'h0000_8001);
      tick;
      launch(4'd1, 32'h8000_0002, 32'd0);
      wait_done("lh", cyc);
      chk("lh_rdata", rdata_o, 32'hFFFF_8001);
      tick;

      // SH to upper half
      launch(4'd9, 32'h8000_0102, 32'h0000_BEEF);
      chk("sh_awvalid", {30'd0, awvalid_o, wvalid_o}, 32'd3);
      chk("sh_arvalid", {31'd0, arvalid_o}, 32'd0);
      chk("sh_awaddr", awaddr_o, 32'h8000_0100);
      chk("sh_wdata", wdata_o, 32'hBEEF_0000);
      chk("sh_wstrb", {28'd0, wstrb_o}, 32'hC);
      tick;
      chk("sh_bready", {29'd0, bready_o, awvalid_o, wvalid_o}, 32'd4);
      tick;
      chk("sh_done_c3", {31'd0, access_done_o}, 32'd1);
      chk("sh_rdata_kept", rdata_o, 32'hFFFF_8001);
      chk("sh_fault", {31'd0, fault_o}, 32'd0);
      tick;

      // SW with awready held off
      awready_i = 1'b0;
      launch(4'd10, 32'h8000_0200, 32'h1122_3344);
      chk("sw_c1_valids", {30'd0, awvalid_o, wvalid_o}, 32'd3);
      chk("sw_wstrb", {28'd0, wstrb_o}, 32'hF);
      chk("sw_wdata", wdata_o, 32'h1122_3344);
      tick;
      chk("sw_c2_valids", {30'd0, awvalid_o, wvalid_o}, 32'd2);
      chk("sw_c2_awaddr", awaddr_o, 32'h8000_0200);
      chk("sw_c2_done", {31'd0, access_done_o}, 32'd0);
      tick;
      chk("sw_c3_valids", {30'd0, awvalid_o, wvalid_o}, 32'd2);
      awready_i = 1'b1;
      tick;
      awready_i = 1'b0;
      chk("sw_c4_bready", {29'd0, bready_o, awvalid_o, wvalid_o}, 32'd4);
      chk("sw_c4_done", {31'd0, access_done_o}, 32'd0);
      tick;
      chk("sw_done", {31'd0, access_done_o}, 32'd1);
      tick;
      chk("sw_single_pulse", {31'd0, access_done_o}, 32'd0);
      awready_i = 1'b1;

      // Misaligned LW
      launch(4'd2, 32'h8000_0001, 32'd0);
      chk("mis_done_c1", {31'd0, access_done_o}, 32'd1);
      chk("mis_fault", {31'd0, fault_o}, 32'd1);
      chk("mis_no_bus", {30'd0, arvalid_o, rready_o}, 32'd0);
      tick;
      chk("mis_fault_held", {31'd0, fault_o}, 32'd1);

      // Illegal op code 7
      launch(4'd7, 32'h8000_0000, 32'd0);
      chk("ill_done_c1", {30'd0, access_done_o, fault_o}, 32'd3);
      tick;

      // LW with SLVERR
      rdata_i = 32'h1234_5678; rresp_i = 2'b10;
      launch(4'd2, 32'h8000_0010, 32'd0);
      chk("err_fault_cleared", {31'd0, fault_o}, 32'd0);
      wait_done("err", cyc);
      chk("err_fault", {31'd0, fault_o}, 32'd1);
      chk("err_rdata", rdata_o, 32'h1234_5678);
      tick;
      rresp_i = 2'b00;

      // Reset during RD_DATA
      rvalid_i = 1'b0;
      launch(4'd2, 32'h8000_0020, 32'd0);
      tick;
      chk("rst_mid_rready", {31'd0, rready_o}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_outs", {access_done_o, fault_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, wstrb_o}, 32'd0);
      chk("rst_mid_rdata", rdata_o, 32'd0);
      chk("rst_mid_addr", araddr_o, 32'd0);
      @(posedge clock);
      #3 reset = 1'b1;
      tick;
      rvalid_i = 1'b1; rdata_i = 32'hCAFE_F00D;
      launch(4'd2, 32'h8000_0004, 32'd0);
      wait_done("post_rst", cyc);
      chk("post_rst_cyc", cyc, 3);
      chk("post_rst_rdata", rdata_o, 32'hCAFE_F00D);
      chk("post_rst_fault", {31'd0, fault_o}, 32'd0);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
